lsu_mem_stage: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline; sits directly downstream of the Execute stage.
- Consumes the ALU result as the effective address, plus the store data and memory controls latched in EX/MEM.
- Runs a single-outstanding request/grant/rvalid transaction to data memory, formats load data, and produces the registered MEM/WB payload.
- Stalls upstream while a transaction is in flight.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_mem_stage_load_align.sv | 27 ++
 rtl/lsu_mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store memory stage.
// Holds the FSM state type, funct3 encodings, fault causes and access legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b11;

  function automatic logic is_legal_load(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_store(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    case (f3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Load data formatter: picks the addressed byte/half lane out of the read word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[{offset, 3'b000} +: 8];
    half_val = rdata[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    result = {{24{byte_val[7]}}, byte_val};
      F3_BU:   result = {24'b0, byte_val};
      F3_H:    result = {{16{half_val[15]}}, half_val};
      F3_HU:   result = {16'b0, half_val};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I memory stage: single-outstanding req/gnt/rvalid data memory access,
// load formatting, fault detection and the registered MEM/WB payload.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255,
  parameter int XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_write_o,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o
);

  // Counter only needs to reach WAIT_TIMEOUT-1; the last REQ/WAIT cycle is the abort cycle.
  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  lsu_state_e state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [1:0] offset_q, offset_next;
  logic [2:0] f3_q, f3_next;
  logic [4:0] rd_q, rd_next;
  logic       rw_q, rw_next;
  logic       load_q, load_next;

  logic            req_next, we_next;
  logic [XLEN-1:0] addr_next, wdata_next;
  logic [3:0]      be_next;

  logic            wb_valid_next, wb_rw_next, fault_next;
  logic [XLEN-1:0] wb_data_next;
  logic [4:0]      wb_rd_next;
  logic [1:0]      cause_next;

  logic [31:0] load_result;
  logic        timed_out, illegal, misaligned;
  logic        finish_load, finish_store, abort;

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .offset (offset_q),
    .funct3 (f3_q),
    .result (load_result)
  );

  assign stall_o = (state != IDLE);

  assign timed_out = (WAIT_TIMEOUT != 0) && (cnt == CNT_W'(WAIT_TIMEOUT - 1));

  assign illegal = (mem_read_i && mem_write_i)
                || (mem_read_i && !is_legal_load(funct3_i))
                || (mem_write_i && !is_legal_store(funct3_i));

  assign misaligned = is_misaligned(funct3_i, alu_res_i[1:0]);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    offset_next   = offset_q;
    f3_next       = f3_q;
    rd_next       = rd_q;
    rw_next       = rw_q;
    load_next     = load_q;
    req_next      = dmem_req_o;
    we_next       = dmem_we_o;
    addr_next     = dmem_addr_o;
    be_next       = dmem_be_o;
    wdata_next    = dmem_wdata_o;
    wb_valid_next = 1'b0;
    wb_data_next  = '0;
    wb_rd_next    = '0;
    wb_rw_next    = 1'b0;
    fault_next    = 1'b0;
    cause_next    = CAUSE_NONE;
    finish_load   = 1'b0;
    finish_store  = 1'b0;
    abort         = 1'b0;

    case (state)
      IDLE: begin
        if (valid_i) begin
          if (!mem_read_i && !mem_write_i) begin
            wb_valid_next = 1'b1;
            wb_data_next  = alu_res_i;
            wb_rd_next    = rd_i;
            wb_rw_next    = reg_write_i;
          end else if (illegal || misaligned) begin
            wb_valid_next = 1'b1;
            wb_data_next  = alu_res_i;
            wb_rd_next    = rd_i;
            fault_next    = 1'b1;
            cause_next    = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
          end else begin
            state_next  = REQ;
            offset_next = alu_res_i[1:0];
            f3_next     = funct3_i;
            rd_next     = rd_i;
            rw_next     = reg_write_i;
            load_next   = mem_read_i;
            req_next    = 1'b1;
            we_next     = mem_write_i;
            addr_next   = {alu_res_i[XLEN-1:2], 2'b00};
            // Size lives in funct3[1:0]; the unsigned-load bit does not affect lanes.
            case (funct3_i[1:0])
              2'b00: begin
                be_next    = 4'b0001 << alu_res_i[1:0];
                wdata_next = {4{store_data_i[7:0]}};
              end
              2'b01: begin
                be_next    = 4'b0011 << alu_res_i[1:0];
                wdata_next = {2{store_data_i[15:0]}};
              end
              default: begin
                be_next    = 4'b1111;
                wdata_next = store_data_i;
              end
            endcase
          end
        end
      end

      REQ: begin
        // A completion in the same cycle as the timeout still wins.
        if (dmem_gnt_i) begin
          if (!load_q)            finish_store = 1'b1;
          else if (dmem_rvalid_i) finish_load  = 1'b1;
          else if (timed_out)     abort        = 1'b1;
          else                    state_next   = WAIT;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end

      WAIT: begin
        if (dmem_rvalid_i)  finish_load = 1'b1;
        else if (timed_out) abort       = 1'b1;
      end

      default: state_next = IDLE;
    endcase

    if (finish_store) begin
      state_next    = IDLE;
      wb_valid_next = 1'b1;
      wb_rd_next    = rd_q;
    end

    if (finish_load) begin
      state_next    = IDLE;
      wb_valid_next = 1'b1;
      wb_data_next  = load_result;
      wb_rd_next    = rd_q;
      wb_rw_next    = rw_q;
    end

    if (abort) begin
      state_next    = IDLE;
      wb_valid_next = 1'b1;
      wb_rd_next    = rd_q;
      fault_next    = 1'b1;
      cause_next    = CAUSE_TIMEOUT;
    end

    if (state_next != REQ) begin
      req_next   = 1'b0;
      we_next    = 1'b0;
      addr_next  = '0;
      be_next    = '0;
      wdata_next = '0;
    end

    if (state == IDLE || state_next == IDLE) cnt_next = '0;
    else                                     cnt_next = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cnt            <= '0;
      offset_q       <= '0;
      f3_q           <= '0;
      rd_q           <= '0;
      rw_q           <= 1'b0;
      load_q         <= 1'b0;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_be_o      <= '0;
      dmem_wdata_o   <= '0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_rd_o        <= '0;
      wb_reg_write_o <= 1'b0;
      fault_o        <= 1'b0;
      fault_cause_o  <= CAUSE_NONE;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      offset_q       <= offset_next;
      f3_q           <= f3_next;
      rd_q           <= rd_next;
      rw_q           <= rw_next;
      load_q         <= load_next;
      dmem_req_o     <= req_next;
      dmem_we_o      <= we_next;
      dmem_addr_o    <= addr_next;
      dmem_be_o      <= be_next;
      dmem_wdata_o   <= wdata_next;
      wb_valid_o     <= wb_valid_next;
      wb_data_o      <= wb_data_next;
      wb_rd_o        <= wb_rd_next;
      wb_reg_write_o <= wb_rw_next;
      fault_o        <= fault_next;
      fault_cause_o  <= cause_next;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized traffic
// against a behavioural model of the access rules and a programmable bus responder.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int K_ALU = 0, K_BUS = 1, K_MISALIGNED = 2, K_ILLEGAL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] alu_res = '0;
  logic [31:0] store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_reg_write, fault;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  fault_cause;

  int check_count = 0;
  int pass_count = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.WAIT_TIMEOUT(TIMEOUT), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .valid_i        (valid),
    .alu_res_i      (alu_res),
    .store_data_i   (store_data),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .funct3_i       (funct3),
    .rd_i           (rd),
    .reg_write_i    (reg_write),
    .stall_o        (stall),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_be_o      (dmem_be),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_gnt_i     (dmem_gnt),
    .dmem_rvalid_i  (dmem_rvalid),
    .dmem_rdata_i   (dmem_rdata),
    .wb_valid_o     (wb_valid),
    .wb_data_o      (wb_data),
    .wb_rd_o        (wb_rd),
    .wb_reg_write_o (wb_reg_write),
    .fault_o        (fault),
    .fault_cause_o  (fault_cause)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int classify(input logic rd_op, input logic wr_op, input logic [2:0] f3, input logic [31:0] addr);
    if (!rd_op && !wr_op) return K_ALU;
    if (rd_op && wr_op) return K_ILLEGAL;
    if (rd_op && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return K_ILLEGAL;
    if (wr_op && !(f3 inside {3'd0, 3'd1, 3'd2})) return K_ILLEGAL;
    if ((addr % accessSize(f3)) != 0) return K_MISALIGNED;
    return K_BUS;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] shifted;
    int v;
    shifted = word >> (8 * a);
    case (f3)
      3'd0: begin v = int'(shifted & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
      3'd1: begin v = int'(shifted & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
      3'd4: return shifted & 32'hFF;
      3'd5: return shifted & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [1:0] a);
    return 4'(((1 << accessSize(f3)) - 1) << a);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sdata);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sdata[8*(k % accessSize(f3)) +: 8];
    return w;
  endfunction

  // stuck: the responder never sends rvalid (and the caller picks gnt_delay past the timeout for stores).
  task automatic applyStimulus(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd_idx,
                               input logic rw, input int gnt_delay, input int rv_delay, input bit stuck,
                               input logic [31:0] word);
    int kind, expect_cycles, stall_cycles;
    bit granted, gnt_now, rv_now, seen, bus_bad;
    kind = classify(rd_op, wr_op, f3, addr);
    @(negedge clk);
    valid = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3;
    alu_res = addr; store_data = sdata; rd = rd_idx; reg_write = rw;
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_res = $urandom; store_data = $urandom;
    if (kind != K_BUS) begin
      checkOutput("direct_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("direct_no_req", 32'(dmem_req), 32'd0);
      checkOutput("direct_no_stall", 32'(stall), 32'd0);
      checkOutput("direct_rd", 32'(wb_rd), 32'(rd_idx));
      if (kind == K_ALU) begin
        checkOutput("alu_data", wb_data, addr);
        checkOutput("alu_rw", 32'(wb_reg_write), 32'(rw));
        checkOutput("alu_fault", 32'(fault), 32'd0);
      end else begin
        checkOutput("fault_flag", 32'(fault), 32'd1);
        checkOutput("fault_cause", 32'(fault_cause), (kind == K_ILLEGAL) ? 32'd3 : 32'd1);
        checkOutput("fault_rw", 32'(wb_reg_write), 32'd0);
      end
    end else begin
      expect_cycles = stuck ? TIMEOUT : (wr_op ? gnt_delay + 1 : gnt_delay + rv_delay + 1);
      checkOutput("req_first", 32'(dmem_req), 32'd1);
      checkOutput("we_first", 32'(dmem_we), 32'(wr_op));
      checkOutput("addr_first", dmem_addr, {addr[31:2], 2'b00});
      if (wr_op) begin
        checkOutput("be_first", 32'(dmem_be), 32'(modelBe(f3, addr[1:0])));
        checkOutput("wdata_first", dmem_wdata, modelWdata(f3, sdata));
      end
      stall_cycles = 0; granted = 0; seen = 0; bus_bad = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
        if (wb_valid) begin
          seen = 1;
        end else begin
          if (stall) stall_cycles++;
          if (!granted) begin
            if (dmem_req !== 1'b1 || dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== wr_op) bus_bad = 1;
            if (wr_op && (dmem_be !== modelBe(f3, addr[1:0]) || dmem_wdata !== modelWdata(f3, sdata))) bus_bad = 1;
          end else if (dmem_req !== 1'b0) begin
            bus_bad = 1;
          end
          gnt_now = !granted && (i == gnt_delay);
          rv_now  = rd_op && !stuck && (granted || gnt_now) && (i == gnt_delay + rv_delay);
          dmem_gnt = gnt_now; dmem_rvalid = rv_now; dmem_rdata = rv_now ? word : $urandom;
          @(posedge clk); #1;
          dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
          if (gnt_now) granted = 1;
        end
      end
      checkOutput("wb_seen", 32'(seen), 32'd1);
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(expect_cycles));
      checkOutput("bus_stable", 32'(bus_bad), 32'd0);
      checkOutput("req_dropped", 32'(dmem_req), 32'd0);
      checkOutput("done_no_stall", 32'(stall), 32'd0);
      checkOutput("bus_rd", 32'(wb_rd), 32'(rd_idx));
      if (stuck) begin
        checkOutput("timeout_fault", 32'(fault), 32'd1);
        checkOutput("timeout_cause", 32'(fault_cause), 32'd2);
        checkOutput("timeout_rw", 32'(wb_reg_write), 32'd0);
      end else if (wr_op) begin
        checkOutput("store_fault", 32'(fault), 32'd0);
        checkOutput("store_rw", 32'(wb_reg_write), 32'd0);
      end else begin
        checkOutput("load_fault", 32'(fault), 32'd0);
        checkOutput("load_rw", 32'(wb_reg_write), 32'(rw));
        checkOutput("load_data", wb_data, modelLoad(word, addr[1:0], f3));
      end
    end
    // A stray rvalid after an abort must not produce another write-back.
    dmem_rvalid = stuck;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    checkOutput("wb_pulse", 32'(wb_valid), 32'd0);
    checkOutput("idle_after", 32'(stall), 32'd0);
  endtask

  task automatic resetMidTxn(input bit in_wait);
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W;
    alu_res = 32'h0000_5000; rd = 5'd9; reg_write = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0;
    if (in_wait) begin
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
    end
    checkOutput("pre_reset_stall", 32'(stall), 32'd1);
    checkOutput("pre_reset_req", 32'(dmem_req), in_wait ? 32'd0 : 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_stall", 32'(stall), 32'd0);
    checkOutput("async_req", 32'(dmem_req), 32'd0);
    checkOutput("async_addr", dmem_addr, 32'd0);
    checkOutput("async_wb", {27'd0, wb_valid, wb_reg_write, fault, fault_cause}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic rd_op, wr_op, stuck;
    logic [2:0] f3;
    int roll, gd;
    logic [2:0] load_f3 [5];
    load_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_bus", {27'd0, dmem_req, dmem_be}, 32'd0);
    checkOutput("reset_addr", dmem_addr, 32'd0);
    checkOutput("reset_wdata", dmem_wdata, 32'd0);
    checkOutput("reset_wb", {26'd0, wb_valid, wb_reg_write, fault, fault_cause, dmem_we}, 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    checkOutput("reset_wb_rd", 32'(wb_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, F3_B, 32'h0000_1003, 32'h0, 5'd7, 1, 0, 2, 0, 32'h80AB_CDEF);
    applyStimulus(1, 0, F3_BU, 32'h0000_1003, 32'h0, 5'd7, 1, 0, 2, 0, 32'h80AB_CDEF);
    applyStimulus(0, 1, F3_H, 32'h0000_2002, 32'h0000_BEEF, 5'd3, 1, 4, 0, 0, 32'h0);
    applyStimulus(1, 0, F3_W, 32'h0000_3001, 32'h0, 5'd4, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, F3_W, 32'h0000_3000, 32'h0, 5'd4, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 3'd3, 32'h0000_3000, 32'h0, 5'd4, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, F3_HU, 32'h0000_3002, 32'h0, 5'd6, 1, 1, 0, 0, 32'h9876_5432);
    applyStimulus(1, 0, F3_W, 32'h0000_4000, 32'h0, 5'd8, 1, 0, 0, 1, 32'h0);
    applyStimulus(0, 1, F3_W, 32'h0000_4004, 32'h1111_2222, 5'd8, 1, 20, 0, 1, 32'h0);

    $display("[TB] reset during a transaction");
    resetMidTxn(1);
    applyStimulus(1, 0, F3_H, 32'h0000_5002, 32'h0, 5'd10, 1, 1, 1, 0, 32'hC001_7F00);
    resetMidTxn(0);
    applyStimulus(1, 0, F3_W, 32'h0000_5004, 32'h0, 5'd11, 1, 0, 0, 0, 32'h1357_9BDF);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 80; n++) begin
      roll = $urandom_range(0, 9);
      rd_op = (roll >= 2 && roll <= 4) || roll >= 8;
      wr_op = (roll >= 5 && roll <= 8);
      if (roll == 9)      f3 = 3'($urandom_range(0, 7));
      else if (rd_op)     f3 = load_f3[$urandom_range(0, 4)];
      else if (wr_op)     f3 = 3'($urandom_range(0, 2));
      else                f3 = 3'($urandom_range(0, 7));
      stuck = rd_op && !wr_op && ($urandom_range(0, 9) == 0);
      gd = stuck ? $urandom_range(0, 10) : $urandom_range(0, 3);
      applyStimulus(rd_op, wr_op, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), gd, $urandom_range(0, 3), stuck, $urandom);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
